// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: runs core load/store requests as valid/ready bus transactions with stall, misalignment and timeout reporting
module lsu_bus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [3:0]    r_be;
    logic          w_mis;
    logic          w_tmo;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    // alignment check, lane enables and replicated store data for the request in execute
    always_comb begin
        w_mis   = (cpu_size == 2'b11) | ((cpu_size == 2'b01) & cpu_addr[0]) | ((cpu_size == 2'b10) & (|cpu_addr[1:0]));
        w_be    = (cpu_size == 2'b00) ? 4'b0001 << cpu_addr[1:0] :
                  (cpu_size == 2'b01) ? 4'b0011 << cpu_addr[1:0] : 4'b1111;
        w_wdata = !cpu_we             ? 32'h0 :
                  (cpu_size == 2'b00) ? {4{cpu_wdata[7:0]}} :
                  (cpu_size == 2'b01) ? {2{cpu_wdata[15:0]}} : cpu_wdata;
        w_tmo   = r_cnt >= CW'(TIMEOUT - 1);
    end

    assign cpu_stall = reset & (((r_state == IDLE) & cpu_req) | (r_state == REQ) | (r_state == WAIT));
    assign cpu_done  = r_state == RESP;
    assign cpu_err   = (r_state == RESP) & r_err;
    assign cpu_rdata = r_rdata;
    assign bus_valid = r_state == REQ;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

    // transaction sequencer; a completing handshake in the last counted cycle beats the timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_be    <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req && w_mis) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else if (cpu_req) begin
                        r_addr  <= {cpu_addr[31:2], 2'b00};
                        r_we    <= cpu_we;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_ready) begin
                        r_state <= WAIT;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rvalid) begin
                        r_err   <= bus_err;
                        r_state <= RESP;
                        if (!r_we && !bus_err) r_rdata <= bus_rdata;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: scoreboard bench for the load/store bus bridge
module tb_lsu_bus_bridge;
    localparam int T = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nbus;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err = 1'b0;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_bus_bridge #(.TIMEOUT(T), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus_valid), 32'd0);
        check({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        check({tag, "_done"}, 32'(cpu_done), 32'd0);
        check({tag, "_err"}, 32'(cpu_err), 32'd0);
        check({tag, "_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_addr"}, bus_addr, 32'd0);
        check({tag, "_be"}, 32'(bus_be), 32'd0);
        check({tag, "_wdata"}, bus_wdata, 32'd0);
        check({tag, "_we"}, 32'(bus_we), 32'd0);
    endtask

    // one core access; rdy = REQ cycles before ready, rv = WAIT cycles before rvalid
    task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input int rdy, input int rv, input logic [31:0] rdata, input logic berr);
        logic        mis, tq, tw, got, vs, acc;
        logic [3:0]  be;
        logic [31:0] bwd;
        int          c, vcnt, wcnt, nbus;
        exp_t        e, p;
        mis = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        for (int i = 0; i < 4; i++) begin
            be[i] = size == 2'd2 || (size == 2'd0 && i == int'(addr[1:0])) || (size == 2'd1 && i / 2 == int'(addr[1]));
            bwd[8*i+:8] = !we ? 8'h00 : size == 2'd0 ? wdata[7:0] : size == 2'd1 ? wdata[8*(i%2)+:8] : wdata[8*i+:8];
        end
        tq = !mis && rdy >= T;
        tw = !mis && !tq && rv > 0 && rdy + 1 + rv >= T;
        e.err = mis || tq || tw || berr;
        if (!e.err && !we) m_rdata = rdata;
        e.rdata = m_rdata;
        e.lat = mis ? 1 : (tq || tw) ? T + 1 : rdy + rv + 3;
        e.nbus = mis ? 0 : tq ? T : rdy + 1;
        sb.push_back(e);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_size = size;
        cpu_addr = addr;
        cpu_wdata = wdata;
        c = 0;
        vcnt = 0;
        wcnt = 0;
        nbus = 0;
        acc = 1'b0;
        got = 1'b0;
        while (!got && c < 40) begin
            bus_ready = bus_valid && vcnt == rdy;
            bus_rvalid = acc && wcnt == rv;
            bus_rdata = bus_rvalid ? rdata : $urandom;
            bus_err = bus_rvalid && berr;
            @(negedge clk);
            vs = bus_valid;
            if (vs) begin
                nbus++;
                check("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check("bus_be", 32'(bus_be), 32'(be));
                check("bus_wdata", bus_wdata, bwd);
                check("bus_we", 32'(bus_we), 32'(we));
            end
            check("stall", 32'(cpu_stall), 32'(c != e.lat));
            if (cpu_done) begin
                got = 1'b1;
                p = sb.pop_front();
                check("err", 32'(cpu_err), 32'(p.err));
                check("rdata", cpu_rdata, p.rdata);
                check("latency", c, p.lat);
                check("bus_cycles", nbus, p.nbus);
            end
            @(posedge clk);
            #1;
            if (got) cpu_req = 1'b0;
            if (vs && bus_ready) acc = 1'b1;
            else if (vs) vcnt++;
            else if (acc) wcnt++;
            bus_ready = 1'b0;
            bus_rvalid = 1'b0;
            bus_err = 1'b0;
            c++;
        end
        check("done_seen", 32'(got), 32'd1);
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_idle_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 2'b10, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        bus_rvalid = 1'b1;
        bus_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        txn(1'b1, 2'b00, 32'h0000_0203, 32'h0000_005A, 0, 0, 32'h3333_4444, 1'b0);
        txn(1'b0, 2'b01, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(1'b0, 2'b11, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(1'b0, 2'b10, 32'h0000_0300, 32'h0, 3, 0, 32'h1234_5678, 1'b0);
        txn(1'b0, 2'b10, 32'h0000_0400, 32'h0, 99, 0, 32'hBAD0_BAD0, 1'b0);
        txn(1'b0, 2'b10, 32'h0000_0404, 32'h0, 0, 2, 32'hA5A5_0F0F, 1'b0);
        txn(1'b0, 2'b10, 32'h0000_0408, 32'h0, 0, 9, 32'h7777_7777, 1'b0);
        txn(1'b1, 2'b01, 32'h0000_0102, 32'h1234_ABCD, 1, 1, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 32'h0000_0101, 32'hFFFF_FFFF, 1, 0, 32'h0000_00C3, 1'b0);
        txn(1'b0, 2'b10, 32'h0000_0600, 32'h0, 0, 1, 32'h5555_AAAA, 1'b1);
        txn(1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, 2, 0, 32'h0, 1'b0);
        txn(1'b0, 2'b01, 32'h0000_0042, 32'h0, 0, 0, 32'h0000_BEEF, 1'b0);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_size = 2'b10;
        cpu_addr = 32'h0000_0500;
        @(posedge clk);
        #1;
        bus_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        m_rdata = 32'h0;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hCAFE_CAFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(cpu_done), 32'd0);
            check("post_rst_rdata", cpu_rdata, m_rdata);
        end
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        txn(1'b0, 2'b10, 32'h0000_0700, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
